// File: rtl/sevenseg_capture_if.sv
// Pin-side bundle for the 7-segment receive monitor: the display bus plus the
// recovered value and error outputs.
interface sevenseg_capture_if;
  logic [6:0]  seg;
  logic [3:0]  en;
  logic        err_clr;
  logic [15:0] value;
  logic        value_valid;
  logic        digit_err;
  logic [1:0]  err_idx;

  modport master (
    output seg, en, err_clr,
    input  value, value_valid, digit_err, err_idx
  );

  modport slave (
    input  seg, en, err_clr,
    output value, value_valid, digit_err, err_idx
  );
endinterface

// File: rtl/sevenseg_capture.sv
// Recovers a hex value from an active-low multiplexed 7-segment bus.
// Optional macro SEVENSEG_CAPTURE_STICKY_ERR_EN makes digit_err sticky until err_clr.
//
// state | meaning
// TRACK | waiting for the registered {en,seg} to stay stable STABLE_CYCLES samples
// HELD  | stable pair already evaluated; wait for the next change
module sevenseg_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int DIGITS        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sevenseg_capture_if.slave bus
);

  typedef enum logic {TRACK = 1'b0, HELD = 1'b1} state_t;

  localparam logic [7:0] RUN_MAX  = 8'(STABLE_CYCLES);
  localparam logic [3:0] DIG_MASK = 4'((1 << DIGITS) - 1);

  state_t           state_q, state_d;
  logic [10:0]      in_q, in_d;
  logic [7:0]       run_q, run_d;
  logic [3:0][3:0]  slot_q, slot_d;
  logic [3:0]       seen_q, seen_d;
  logic             err_pend_q, err_pend_d;
  logic [1:0]       err_pidx_q, err_pidx_d;
  logic [15:0]      value_q, value_d;
  logic             valid_q, valid_d;
  logic             digit_err_q, digit_err_d;
  logic [1:0]       err_idx_q, err_idx_d;
  logic             changed, do_eval;
  logic [3:0]       en_s;
  logic [6:0]       seg_s;
  logic [4:0]       dec;
  logic [1:0]       low_idx;

  // Returns {valid, nibble}; segments are active-low, seg[6] = a.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 5'h10;
      7'b1001111: decode = 5'h11;
      7'b0010010: decode = 5'h12;
      7'b0000110: decode = 5'h13;
      7'b1001100: decode = 5'h14;
      7'b0100100: decode = 5'h15;
      7'b0100000: decode = 5'h16;
      7'b0001111: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0000100: decode = 5'h19;
      7'b0000010: decode = 5'h1A;
      7'b1100000: decode = 5'h1B;
      7'b0110001: decode = 5'h1C;
      7'b1000010: decode = 5'h1D;
      7'b0010000: decode = 5'h1E;
      7'b0111000: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  always_comb begin : fsm_next
    in_d    = {bus.en, bus.seg};
    changed = (in_d != in_q);
    if (changed)              run_d = 8'd1;
    else if (run_q < RUN_MAX) run_d = run_q + 8'd1;
    else                      run_d = run_q;

    state_d = state_q;
    do_eval = 1'b0;
    case (state_q)
      TRACK: begin
        if (run_q == RUN_MAX) begin
          do_eval = 1'b1;
          state_d = HELD;
        end
      end
      HELD:    state_d = HELD;
      default: state_d = TRACK;
    endcase
    // The pair being replaced is still evaluated if it just made its run.
    if (changed) state_d = TRACK;
  end

  always_comb begin : datapath
    en_s       = in_q[10:7];
    seg_s      = in_q[6:0];
    dec        = decode(seg_s);
    low_idx    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!en_s[i]) low_idx = 2'(i);
    end

    slot_d     = slot_q;
    seen_d     = seen_q;
    err_pend_d = 1'b0;
    err_pidx_d = err_pidx_q;
    value_d    = value_q;
    valid_d    = 1'b0;

    if ((seen_q & DIG_MASK) == DIG_MASK) begin
      value_d = slot_q;
      valid_d = 1'b1;
      seen_d  = 4'b0000;
    end

    if (do_eval && (en_s != 4'hF)) begin
      if ($countones(~en_s) == 1) begin
        if (DIG_MASK[low_idx]) begin
          if (dec[4]) begin
            slot_d[low_idx] = dec[3:0];
            seen_d[low_idx] = 1'b1;
          end else begin
            err_pend_d      = 1'b1;
            err_pidx_d      = low_idx;
            seen_d[low_idx] = 1'b0;
          end
        end
      end else begin
        err_pend_d = 1'b1;
        err_pidx_d = low_idx;
        seen_d     = 4'b0000;
      end
    end

    err_idx_d = err_pend_q ? err_pidx_q : err_idx_q;
`ifdef SEVENSEG_CAPTURE_STICKY_ERR_EN
    if (bus.err_clr)     digit_err_d = 1'b0;
    else if (err_pend_q) digit_err_d = 1'b1;
    else                 digit_err_d = digit_err_q;
`else
    digit_err_d = err_pend_q;
`endif
  end

`ifndef SEVENSEG_CAPTURE_STICKY_ERR_EN
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= TRACK;
      in_q        <= '1;
      run_q       <= 8'd0;
      slot_q      <= '0;
      seen_q      <= 4'b0000;
      err_pend_q  <= 1'b0;
      err_pidx_q  <= 2'd0;
      value_q     <= 16'h0000;
      valid_q     <= 1'b0;
      digit_err_q <= 1'b0;
      err_idx_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_q        <= in_d;
      run_q       <= run_d;
      slot_q      <= slot_d;
      seen_q      <= seen_d;
      err_pend_q  <= err_pend_d;
      err_pidx_q  <= err_pidx_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      digit_err_q <= digit_err_d;
      err_idx_q   <= err_idx_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = valid_q;
  assign bus.digit_err   = digit_err_q;
  assign bus.err_idx     = err_idx_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Scoreboard bench for sevenseg_capture: a 4-digit and a 1-digit instance,
// expected values/errors queued when stimulus is driven.
module tb_sevenseg_capture;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_capture_if bus ();
  sevenseg_capture_if bus1 ();

  sevenseg_capture #(.STABLE_CYCLES(S), .DIGITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  sevenseg_capture #(.STABLE_CYCLES(S), .DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0010000, 7'b0111000};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nvalid0 = 0, nvalid1 = 0, nerr0 = 0, valid_cyc1 = 0;
  logic err_prev = 1'b0;
  logic [15:0] ev, ev1;
  logic [1:0]  eidx;

  logic [15:0] exp_val[$];
  logic [15:0] exp_val1[$];
  logic [1:0]  exp_err[$];
  logic [3:0]  m_slot [2][4];
  logic [3:0]  m_seen [2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.value_valid) begin
        nvalid0++;
        checks++;
        if (exp_val.size() == 0) begin
          errors++;
          $display("FAIL value4_unexpected: got %h with no value expected", bus.value);
        end else begin
          ev = exp_val.pop_front();
          if (bus.value !== ev) begin
            errors++;
            $display("FAIL value4: got %h expected %h", bus.value, ev);
          end
        end
      end
      if (bus1.value_valid) begin
        nvalid1++;
        valid_cyc1 = cyc;
        checks++;
        if (exp_val1.size() == 0) begin
          errors++;
          $display("FAIL value1_unexpected: got %h with no value expected", bus1.value);
        end else begin
          ev1 = exp_val1.pop_front();
          if (bus1.value !== ev1) begin
            errors++;
            $display("FAIL value1: got %h expected %h", bus1.value, ev1);
          end
        end
      end
      if (bus.digit_err && !err_prev) begin
        nerr0++;
        checks++;
        if (exp_err.size() == 0) begin
          errors++;
          $display("FAIL err_unexpected: err_idx=%0d with no error expected", bus.err_idx);
        end else begin
          eidx = exp_err.pop_front();
          if (bus.err_idx !== eidx) begin
            errors++;
            $display("FAIL err_idx: got %0d expected %0d", bus.err_idx, eidx);
          end
        end
      end
`ifndef SEVENSEG_CAPTURE_STICKY_ERR_EN
      if (bus.digit_err) begin
        checks++;
        if (err_prev) begin
          errors++;
          $display("FAIL err_pulse_width: digit_err high %0d cycles, expected 1", 2);
        end
      end
`endif
      err_prev = bus.digit_err;
    end else begin
      err_prev = 1'b0;
    end
  end

  function automatic int dec_model(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_seen[w] = 4'b0000;
      for (int i = 0; i < 4; i++) m_slot[w][i] = 4'h0;
    end
  endtask

  task automatic model_eval(input int w, input logic [3:0] e, input logic [6:0] s);
    int dg, nlow, lo, d;
    logic full;
    logic [15:0] v;
    dg = (w == 0) ? 4 : 1;
    nlow = 0;
    lo = 0;
    for (int i = 3; i >= 0; i--) if (!e[i]) begin nlow++; lo = i; end
    if (nlow == 0) return;
    if (nlow > 1) begin
      m_seen[w] = 4'b0000;
      if (w == 0) exp_err.push_back(2'(lo));
      return;
    end
    if (lo >= dg) return;
    d = dec_model(s);
    if (d < 0) begin
      m_seen[w][lo] = 1'b0;
      if (w == 0) exp_err.push_back(2'(lo));
      return;
    end
    m_slot[w][lo] = 4'(d);
    m_seen[w][lo] = 1'b1;
    full = 1'b1;
    v = 16'h0000;
    for (int i = 0; i < dg; i++) begin
      if (!m_seen[w][i]) full = 1'b0;
      v[4*i +: 4] = m_slot[w][i];
    end
    if (full) begin
      m_seen[w] = 4'b0000;
      if (w == 0) exp_val.push_back(v);
      else        exp_val1.push_back(v);
    end
  endtask

  task automatic hold(input int w, input logic [3:0] e, input logic [6:0] s, input int n);
    if (w == 0) begin bus.en = e; bus.seg = s; end
    else begin bus1.en = e; bus1.seg = s; end
    if (n >= S) model_eval(w, e, s);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int w, input int n);
    hold(w, 4'hF, 7'h7F, n);
  endtask

  task automatic scan(input logic [15:0] v, input int n);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] e;
      e = 4'hF;
      e[i] = 1'b0;
      hold(0, e, seg_tab[v[4*i +: 4]], n);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    bus.en = 4'hF; bus.seg = 7'h7F; bus.err_clr = 1'b0;
    bus1.en = 4'hF; bus1.seg = 7'h7F; bus1.err_clr = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", bus.value, 16'h0000);
    chk("rst_valid", 16'(bus.value_valid), 16'h0);
    chk("rst_digit_err", 16'(bus.digit_err), 16'h0);
    chk("rst_err_idx", 16'(bus.err_idx), 16'h0);
    chk("rst_value1", bus1.value, 16'h0000);
    rst_n = 1'b1;
    blank(0, 6);
  endtask

  task automatic test_single_digit();
    int nv, m;
    nv = nvalid1;
    m = cyc;
    hold(1, 4'b1110, 7'b0010010, 10);
    blank(1, 6);
    chk("single_pulses", 16'(nvalid1 - nv), 16'd1);
    chk("single_latency", 16'(valid_cyc1 - m), 16'd6);
  endtask

  task automatic test_full_scan();
    int nv;
    nv = nvalid0;
    scan(16'hF0A3, 6);
    blank(0, 4);
    chk("scan_pulses", 16'(nvalid0 - nv), 16'd1);
  endtask

  task automatic test_short_hold();
    int nv, ne;
    nv = nvalid0;
    ne = nerr0;
    for (int i = 0; i < 3; i++) begin
      hold(0, 4'b1110, 7'b0000001, S - 1);
      hold(0, 4'b1101, 7'b0000001, S - 1);
      hold(0, 4'b1011, 7'b1111110, S - 1);
    end
    blank(0, 6);
    chk("short_no_value", 16'(nvalid0 - nv), 16'd0);
    chk("short_no_err", 16'(nerr0 - ne), 16'd0);
  endtask

  task automatic test_invalid_pattern();
    int nv, ne;
    nv = nvalid0;
    ne = nerr0;
    hold(0, 4'b1110, seg_tab[1], 6);
    hold(0, 4'b1101, seg_tab[2], 6);
    hold(0, 4'b1011, seg_tab[4], 6);
    hold(0, 4'b1101, 7'b1111110, 5);
    hold(0, 4'b0111, seg_tab[5], 6);
    chk("invalid_no_value", 16'(nvalid0 - nv), 16'd0);
    chk("invalid_err_count", 16'(nerr0 - ne), 16'd1);
    chk("invalid_err_idx", 16'(bus.err_idx), 16'd1);
    hold(0, 4'b1101, seg_tab[7], 6);
    blank(0, 4);
    chk("invalid_recover", 16'(nvalid0 - nv), 16'd1);
  endtask

  task automatic test_reset_mid_scan();
    int nv;
    hold(0, 4'b1110, seg_tab[8], 6);
    hold(0, 4'b1101, seg_tab[9], 6);
    blank(0, 2);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_value", bus.value, 16'h0000);
    chk("midrst_err_idx", 16'(bus.err_idx), 16'h0);
    rst_n = 1'b1;
    nv = nvalid0;
    hold(0, 4'b1011, seg_tab[11], 6);
    hold(0, 4'b0111, seg_tab[12], 6);
    chk("midrst_partial", 16'(nvalid0 - nv), 16'd0);
    hold(0, 4'b1110, seg_tab[13], 6);
    hold(0, 4'b1101, seg_tab[14], 6);
    blank(0, 4);
    chk("midrst_complete", 16'(nvalid0 - nv), 16'd1);
  endtask

  task automatic test_multi_enable();
    int nv;
    nv = nvalid0;
    hold(0, 4'b1110, seg_tab[1], 6);
    hold(0, 4'b1101, seg_tab[2], 6);
    hold(0, 4'b1100, 7'b0000001, 5);
    hold(0, 4'b0101, 7'b0000110, 5);
    hold(0, 4'b1011, seg_tab[6], 6);
    hold(0, 4'b0111, seg_tab[3], 6);
    chk("multi_discard", 16'(nvalid0 - nv), 16'd0);
    chk("multi_err_idx", 16'(bus.err_idx), 16'd1);
    hold(0, 4'b1110, seg_tab[10], 6);
    hold(0, 4'b1101, seg_tab[0], 6);
    blank(0, 4);
    chk("multi_rescan", 16'(nvalid0 - nv), 16'd1);
  endtask

  task automatic test_back_to_back();
    int nv;
    nv = nvalid0;
    scan(16'h1234, S);
    scan(16'hBEEF, S);
    blank(0, 6);
    chk("b2b_pulses", 16'(nvalid0 - nv), 16'd2);
  endtask

  task automatic test_err_mode();
`ifdef SEVENSEG_CAPTURE_STICKY_ERR_EN
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    exp_err.delete();
    chk("sticky_pre_clear", 16'(bus.digit_err), 16'h0);
    hold(0, 4'b1011, 7'h7F & 7'b1111111, 5);
    chk("sticky_before", 16'(bus.digit_err), 16'h0);
    @(posedge clk);
    #1;
    chk("sticky_set", 16'(bus.digit_err), 16'h1);
    chk("sticky_idx", 16'(bus.err_idx), 16'd2);
    scan(16'h2468, 6);
    blank(0, 4);
    chk("sticky_hold", 16'(bus.digit_err), 16'h1);
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    chk("sticky_clear", 16'(bus.digit_err), 16'h0);
`else
    bus.err_clr = 1'b1;
    hold(0, 4'b1011, 7'b1111111, 5);
    chk("pulse_before", 16'(bus.digit_err), 16'h0);
    @(posedge clk);
    #1;
    chk("pulse_set", 16'(bus.digit_err), 16'h1);
    chk("pulse_idx", 16'(bus.err_idx), 16'd2);
    @(posedge clk);
    #1;
    chk("pulse_drop", 16'(bus.digit_err), 16'h0);
    bus.err_clr = 1'b0;
    scan(16'h2468, 6);
    blank(0, 4);
`endif
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_full_scan();
    test_short_hold();
    test_invalid_pattern();
    test_reset_mid_scan();
    test_multi_enable();
    test_back_to_back();
    test_err_mode();
    blank(0, 8);
    chk("left_values4", 16'(exp_val.size()), 16'd0);
    chk("left_values1", 16'(exp_val1.size()), 16'd0);
    chk("left_errors", 16'(exp_err.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded %0d ns limit", 200000);
    $fatal(1, "timeout");
  end
endmodule
